// File: rtl/status_flag_unit.sv
// NZCV status flag producer: computes execute-stage flags, buffers one pending
// update, commits it to the architectural register one edge later, and forwards it.
module status_flag_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    input  logic             i_Stall,
    input  logic             i_Flush,
    input  logic             i_Cond_Pass,
    input  logic             i_S,
    input  logic [1:0]       i_Op_Class,
    input  logic             i_Cin,
    input  logic [WIDTH-1:0] i_Operand_A,
    input  logic [WIDTH-1:0] i_Operand_B,
    input  logic [WIDTH-1:0] i_Result,
    input  logic             i_Shifter_Carry,
    input  logic             i_Write,
    input  logic [3:0]       i_Write_Data,
    output logic [3:0]       o_Status,
    output logic [3:0]       o_Status_Fwd,
    output logic             o_Pending
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [1:0] OpLogic = 2'b00;
    localparam logic [1:0] OpSub   = 2'b10;
    localparam logic [1:0] OpNone  = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } state_e;

    state_e     state_q;
    logic       pending_q;
    logic [3:0] pend_flags_q;
    logic [3:0] status_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [3:0]       arith_flags;
    logic [3:0]       logic_flags;
    logic [3:0]       new_flags;
    logic [3:0]       status_fwd;
    logic             flag_update;
    logic             accept;

    // Forwarded view depends only on registered state.
    assign status_fwd = pending_q ? pend_flags_q : status_q;

    always_comb begin
        b_eff = (i_Op_Class == OpSub) ? ~i_Operand_B : i_Operand_B;
        sum   = {1'b0, i_Operand_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, i_Cin};

        arith_flags = {
            (sum[Msb:0] == '0),
            sum[WIDTH],
            sum[Msb],
            (i_Operand_A[Msb] == b_eff[Msb]) && (sum[Msb] != i_Operand_A[Msb])
        };

        // Logical ops leave V alone, including a V still waiting to commit.
        logic_flags = {
            (i_Result == '0),
            i_Shifter_Carry,
            i_Result[Msb],
            status_fwd[0]
        };

        if (i_Write) begin
            new_flags = i_Write_Data;
        end else if (i_Op_Class == OpLogic) begin
            new_flags = logic_flags;
        end else begin
            new_flags = arith_flags;
        end
    end

    assign flag_update = i_Write || (i_S && (i_Op_Class != OpNone));
    assign accept      = i_Valid && !i_Stall && !i_Flush && i_Cond_Pass && flag_update;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            pend_flags_q <= 4'b0000;
            status_q     <= 4'b0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        pend_flags_q <= new_flags;
                        pending_q    <= 1'b1;
                        state_q      <= StPending;
                    end
                end
                StPending: begin
                    // Older entry commits on the same edge a newer one loads.
                    if (!i_Stall) begin
                        status_q <= pend_flags_q;
                        if (accept) begin
                            pend_flags_q <= new_flags;
                        end else begin
                            pending_q <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: begin
                    pending_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign o_Status     = status_q;
    assign o_Status_Fwd = status_fwd;
    assign o_Pending    = pending_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Randomized bench for status_flag_unit against a queue-based flag model,
// plus directed scenarios with literal expectations.
module tb_status_flag_unit;

    localparam int unsigned WIDTH = 32;

    logic             i_Clk;
    logic             i_Rst_n;
    logic             i_Valid;
    logic             i_Stall;
    logic             i_Flush;
    logic             i_Cond_Pass;
    logic             i_S;
    logic [1:0]       i_Op_Class;
    logic             i_Cin;
    logic [WIDTH-1:0] i_Operand_A;
    logic [WIDTH-1:0] i_Operand_B;
    logic [WIDTH-1:0] i_Result;
    logic             i_Shifter_Carry;
    logic             i_Write;
    logic [3:0]       i_Write_Data;
    logic [3:0]       o_Status;
    logic [3:0]       o_Status_Fwd;
    logic             o_Pending;

    status_flag_unit #(.WIDTH(WIDTH)) dut (
        .i_Clk           (i_Clk),
        .i_Rst_n         (i_Rst_n),
        .i_Valid         (i_Valid),
        .i_Stall         (i_Stall),
        .i_Flush         (i_Flush),
        .i_Cond_Pass     (i_Cond_Pass),
        .i_S             (i_S),
        .i_Op_Class      (i_Op_Class),
        .i_Cin           (i_Cin),
        .i_Operand_A     (i_Operand_A),
        .i_Operand_B     (i_Operand_B),
        .i_Result        (i_Result),
        .i_Shifter_Carry (i_Shifter_Carry),
        .i_Write         (i_Write),
        .i_Write_Data    (i_Write_Data),
        .o_Status        (o_Status),
        .o_Status_Fwd    (o_Status_Fwd),
        .o_Pending       (o_Pending)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // Model: committed flags plus a FIFO of accepted-but-uncommitted updates.
    logic [3:0] m_arch = 4'b0000;
    logic [3:0] m_pend[$];

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_fwd();
        return (m_pend.size() != 0) ? m_pend[0] : m_arch;
    endfunction

    function automatic logic [3:0] calc_flags(input logic [3:0] vsrc);
        logic [32:0] full;
        logic [31:0] bb;
        logic [31:0] s;
        if (i_Write) return i_Write_Data;
        if (i_Op_Class == 2'b00)
            return {(i_Result == 32'd0), i_Shifter_Carry, i_Result[31], vsrc[0]};
        bb   = (i_Op_Class == 2'b10) ? ~i_Operand_B : i_Operand_B;
        full = 33'(i_Operand_A) + 33'(bb) + 33'(i_Cin);
        s    = full[31:0];
        return {(s == 32'd0), full[32], s[31],
                (i_Operand_A[31] == bb[31]) && (s[31] != i_Operand_A[31])};
    endfunction

    // One clock: evaluate model on pre-edge inputs, advance at the edge.
    task automatic cycle();
        logic [3:0] nf;
        logic       acc;
        nf  = calc_flags(model_fwd());
        acc = i_Valid && !i_Stall && !i_Flush && i_Cond_Pass &&
              (i_Write || (i_S && i_Op_Class != 2'b11));
        @(posedge i_Clk);
        if (!i_Rst_n) begin
            m_arch = 4'b0000;
            m_pend.delete();
        end else begin
            if (!i_Stall && m_pend.size() != 0) m_arch = m_pend.pop_front();
            if (acc) m_pend.push_back(nf);
        end
        #1;
    endtask

    task automatic idle();
        i_Valid = 0; i_Stall = 0; i_Flush = 0; i_Cond_Pass = 1; i_S = 0;
        i_Op_Class = 2'b11; i_Cin = 0; i_Operand_A = '0; i_Operand_B = '0;
        i_Result = '0; i_Shifter_Carry = 0; i_Write = 0; i_Write_Data = 4'b0000;
    endtask

    task automatic ins(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [31:0] res, input logic sc);
        idle();
        i_Valid = 1; i_S = 1; i_Op_Class = op; i_Operand_A = a; i_Operand_B = b;
        i_Cin = cin; i_Result = res; i_Shifter_Carry = sc;
    endtask

    task automatic wr(input logic [3:0] d);
        idle();
        i_Valid = 1; i_Write = 1; i_Write_Data = d;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge i_Clk) begin
        if (chk_en) begin
            check("status", o_Status, m_arch);
            check("pending", {3'b000, o_Pending}, {3'b000, (m_pend.size() != 0)});
            check("status_fwd", o_Status_Fwd, model_fwd());
        end
    end

    initial begin
        idle();
        i_Rst_n = 0;
        #12;
        check("reset_status", o_Status, 4'b0000);
        check("reset_fwd", o_Status_Fwd, 4'b0000);
        check("reset_pending", {3'b000, o_Pending}, 4'b0000);
        @(posedge i_Clk); #1;
        i_Rst_n = 1;
        chk_en  = 1;

        // Signed overflow on add
        ins(2'b01, 32'h7FFF_FFFF, 32'd1, 0, 32'd0, 0); cycle(); idle();
        check("ovf_fwd", o_Status_Fwd, 4'b0011);
        check("ovf_pending", {3'b000, o_Pending}, 4'b0001);
        check("ovf_status_early", o_Status, 4'b0000);
        cycle();
        check("ovf_status", o_Status, 4'b0011);

        // Equal compare, then logical op preserving a pending V
        ins(2'b10, 32'd5, 32'd5, 1, 32'd0, 0); cycle(); idle();
        check("cmp_fwd", o_Status_Fwd, 4'b1100);
        cycle();
        check("cmp_status", o_Status, 4'b1100);
        wr(4'b0001); cycle();
        ins(2'b00, 32'd0, 32'd0, 0, 32'd0, 0); cycle(); idle();
        check("logic_fwd", o_Status_Fwd, 4'b1001);
        cycle();
        check("logic_status", o_Status, 4'b1001);

        // Gated updates
        ins(2'b01, 32'd1, 32'd1, 0, 32'd0, 0); i_Cond_Pass = 0; cycle(); idle();
        check("gate_cond_pend", {3'b000, o_Pending}, 4'b0000);
        check("gate_cond_status", o_Status, 4'b1001);
        ins(2'b01, 32'd1, 32'd1, 0, 32'd0, 0); i_Flush = 1; cycle(); idle();
        check("gate_flush_pend", {3'b000, o_Pending}, 4'b0000);
        check("gate_flush_status", o_Status, 4'b1001);
        ins(2'b11, 32'd1, 32'd1, 0, 32'd0, 0); cycle(); idle();
        check("gate_none_pend", {3'b000, o_Pending}, 4'b0000);
        check("gate_none_status", o_Status, 4'b1001);

        // Back-to-back with stall
        ins(2'b10, 32'd5, 32'd5, 1, 32'd0, 0); cycle();
        check("b2b_fwd1", o_Status_Fwd, 4'b1100);
        ins(2'b01, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 0); cycle(); idle();
        check("b2b_fwd2", o_Status_Fwd, 4'b1100);
        check("b2b_status_mid", o_Status, 4'b1100);
        i_Stall = 1;
        repeat (3) begin
            cycle();
            check("stall_pending", {3'b000, o_Pending}, 4'b0001);
            check("stall_fwd", o_Status_Fwd, 4'b1100);
        end
        i_Stall = 0; cycle();
        check("b2b_status", o_Status, 4'b1100);
        check("b2b_pending", {3'b000, o_Pending}, 4'b0000);

        // Write beats S; flush after accept does not kill the pending entry
        ins(2'b01, 32'd1, 32'd1, 0, 32'd0, 0); i_Write = 1; i_Write_Data = 4'b0101; cycle();
        check("prio_fwd", o_Status_Fwd, 4'b0101);
        ins(2'b10, 32'd5, 32'd5, 1, 32'd0, 0); i_Flush = 1; cycle(); idle();
        check("flush_commit", o_Status, 4'b0101);
        check("flush_pending", {3'b000, o_Pending}, 4'b0000);

        // Asynchronous reset with an entry pending
        wr(4'b1111); cycle(); idle(); cycle();
        check("pre_rst_status", o_Status, 4'b1111);
        wr(4'b0110); cycle(); idle();
        check("pre_rst_pending", {3'b000, o_Pending}, 4'b0001);
        i_Rst_n = 0; m_arch = 4'b0000; m_pend.delete();
        #1;
        check("arst_status", o_Status, 4'b0000);
        check("arst_fwd", o_Status_Fwd, 4'b0000);
        check("arst_pending", {3'b000, o_Pending}, 4'b0000);
        cycle();
        i_Rst_n = 1;
        cycle();
        check("post_rst_status", o_Status, 4'b0000);
        check("post_rst_pending", {3'b000, o_Pending}, 4'b0000);

        // Randomized traffic
        repeat (3000) begin
            i_Valid         = ($urandom_range(0, 9) < 8);
            i_Stall         = ($urandom_range(0, 9) < 2);
            i_Flush         = ($urandom_range(0, 9) == 0);
            i_Cond_Pass     = ($urandom_range(0, 9) < 8);
            i_S             = ($urandom_range(0, 9) < 7);
            i_Op_Class      = 2'($urandom_range(0, 3));
            i_Cin           = 1'($urandom_range(0, 1));
            i_Operand_A     = pick();
            i_Operand_B     = pick();
            i_Result        = pick();
            i_Shifter_Carry = 1'($urandom_range(0, 1));
            i_Write         = ($urandom_range(0, 9) == 0);
            i_Write_Data    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                i_Rst_n = 0;
                m_arch  = 4'b0000;
                m_pend.delete();
            end else begin
                i_Rst_n = 1;
            end
            cycle();
        end
        i_Rst_n = 1;
        idle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Producer of the NZCV status flags consumed by the pipeline's condition evaluation logic. It computes flags for the instruction in the execute stage, buffers one pending update, and commits it to the architectural status register one cycle later. It also presents a forwarded view so the immediately following instruction evaluates its condition against the newest flags. Output packing is {Z,C,N,V}, matching the condition checker's `i_Status` bit order.

## Interface
- `WIDTH`, 32, datapath width of operands and result.

- `i_Clk`  in  1  single clock; all state updates on its rising edge.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_Valid`  in  1  execute-stage instruction valid.
- `i_Stall`  in  1  pipeline stall; freezes both internal stages.
- `i_Flush`  in  1  kills the execute-stage instruction presented this cycle.
- `i_Cond_Pass`  in  1  condition-check result for this instruction.
- `i_S`  in  1  set-flags bit.
- `i_Op_Class`  in  2  00 logical, 01 add (A+B+cin), 10 subtract (A+~B+cin), 11 no flag effect.
- `i_Cin`  in  1  carry-in for add/subtract classes (1 for SUB/CMP, current C for ADC/SBC).
- `i_Operand_A`  in  WIDTH  first operand.
- `i_Operand_B`  in  WIDTH  second operand (post-shifter).
- `i_Result`  in  WIDTH  ALU result, used for logical class only.
- `i_Shifter_Carry`  in  1  barrel-shifter carry-out, logical-class C.
- `i_Write`  in  1  direct flag write (MSR-flags form).
- `i_Write_Data`  in  4  flags for direct write, {Z,C,N,V}.
- `o_Status`  out  4  architectural flags {Z,C,N,V}.
- `o_Status_Fwd`  out  4  pending flags if a pending entry exists, else `o_Status`.
- `o_Pending`  out  1  pending entry valid.

## Operation
- Flag computation (combinational, current inputs):
  - Add: {c, s} = A + B + cin, computed at WIDTH+1 bits; N = s[WIDTH-1]; Z = (s == 0); C = c; V = (A[msb] == B[msb]) && (s[msb] != A[msb]).
  - Subtract: same as add with B replaced by ~B; C = 1 means no borrow.
  - Logical: N = i_Result[msb]; Z = (i_Result == 0); C = i_Shifter_Carry; V = current forwarded V (unchanged).
  - Class 11: no update, regardless of i_S.
- Accept condition: `i_Valid && !i_Stall && !i_Flush && i_Cond_Pass && (i_Write || (i_S && i_Op_Class != 2'b11))`.
- If `i_Write` and `i_S` are both set, `i_Write` wins and `i_Write_Data` is loaded.
- Two states: IDLE (no pending entry) and PENDING.
  - IDLE -> PENDING on accept; the pending register loads the new flags.
  - PENDING, not stalled: commit the pending flags to the architectural register. If accept holds in the same cycle, load the new entry and stay in PENDING; otherwise go to IDLE.
  - PENDING, stalled: hold everything.
- Back-to-back updates are ordered: the older entry commits while the newer one loads in the same edge, so no update is lost.
- The logical-class V uses `o_Status_Fwd[0]`, so it picks up a V still pending from the previous instruction.
- `i_Flush` does not affect an already-pending entry. That entry belongs to an older instruction and still commits.

## Timing
- Reset (asynchronous, any time, including mid-update): architectural flags = 4'b0000, pending invalid. So `o_Status` = 0, `o_Status_Fwd` = 0, `o_Pending` = 0. Any pending entry is discarded.
- Accept at edge k: `o_Pending` = 1 and `o_Status_Fwd` = new flags after edge k. `o_Status` updates after edge k+1, plus any stall cycles.
- `o_Status_Fwd` is a combinational mux of registered state only; it has no combinational path from the inputs.
- `o_Status` and `o_Pending` are direct register outputs.

## Test plan
- Overflow: ADDS A=0x7FFFFFFF, B=0x00000001, cin=0 -> `o_Status_Fwd` = 4'b0011 one edge after accept, `o_Status` = 4'b0011 one edge later.
- Equal compare: SUBS A=5, B=5, cin=1 -> flags 4'b1100. Then logical S with i_Result=0 and shifter carry 0, with prior V=1 -> 4'b1001 (V preserved).
- Gating: accepts with i_Cond_Pass=0, then with i_Flush=1, then with i_Op_Class=11 and i_S=1 -> `o_Pending` stays 0 and `o_Status` is unchanged in every case.
- Back-to-back with stall: SUBS 5-5 followed by ADDS 0xFFFFFFFF+1 on consecutive cycles, then i_Stall=1 for 3 cycles -> `o_Status_Fwd` = 4'b1100, then 4'b1100 (Z,C), held through the stall, with `o_Status` ending at 4'b1100.
- Priority and ordering: i_Write=1 with data 4'b0101 and i_S=1 with an add in the same cycle -> 4'b0101 committed. A flush raised the cycle after an accept -> the pending entry still commits.
- Reset mid-operation: assert i_Rst_n=0 while `o_Pending`=1 and `o_Status`=4'b1111 -> all outputs 0 immediately, without waiting for a clock edge. After release there is no stale commit.
